morse_rx_fifo: RTL and testbench
================================

Name: morse_rx_fifo

Overview:
- Parametrised Morse receiver front end; next generation of the single-character morse input path.
- Synchronises the raw key line and measures mark and space lengths against programmable thresholds.
- Assembles dot/dash sequences up to MAX_SYMBOLS elements long and emits word-separator markers.
- Buffers decoded characters in a DEPTH-entry FIFO with a valid/ready output, so the downstream translator and display can stall without losing characters.

Parameters:
- MAX_SYMBOLS, 6, maximum elements per character; sets out_code width.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the mark/space duration counters; counters saturate at 2^CNT_W-1.
- GLITCH_MIN, 2, marks shorter than this many cycles are ignored.
- DASH_MIN, 4, a mark of this many cycles or more is a dash; shorter valid marks are dots.
- CHAR_GAP, 8, space length in cycles that closes a character.
- WORD_GAP, 20, space length in cycles that emits a word separator; must be greater than CHAR_GAP.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- din  in  1  raw key line, asynchronous; 1 = mark
- out_valid  out  1  FIFO head holds an entry
- out_ready  in  1  consumer accepts the head this cycle
- out_len  out  $clog2(MAX_SYMBOLS+1)  element count of head; 0 = word separator
- out_code  out  MAX_SYMBOLS  bit i = element i (LSB = first element); 1 = dash, 0 = dot; unused bits 0
- out_err  out  1  head character exceeded MAX_SYMBOLS elements
- fifo_count  out  $clog2(DEPTH+1)  current occupancy
- overflow  out  1  sticky; an entry was dropped because the FIFO was full

Behaviour:
- Reset:
  - out_valid=0, out_len=0, out_code=0, out_err=0, fifo_count=0, overflow=0.
  - Synchroniser flops cleared to 0; state=IDLE; both counters=0.
  - Symbol accumulator cleared.
- Input path:
  - Two-flop synchroniser produces ds; a third flop holds ds_q for edge detection.
  - A din change is visible to the FSM 2 cycles later.
  - rise = ds & ~ds_q; fall = ~ds & ds_q.
- Counters:
  - mark_cnt clears on rise and increments each cycle ds=1.
  - space_cnt clears on fall and increments each cycle ds=0.
  - Both saturate at 2^CNT_W-1.
- FSM states: IDLE, MARK, GAP_CHAR, GAP_WORD.
- IDLE: no pending elements and no pending separator. rise -> MARK. Space is not counted.
- MARK: on fall, the mark length L = mark_cnt, counting cycles with ds=1.
  - If L < GLITCH_MIN: discard the mark. Return to GAP_CHAR if elements are pending, else to the state held before the mark. space_cnt restarts at 0.
  - Else, if fewer than MAX_SYMBOLS elements are pending: append dash if L >= DASH_MIN, otherwise dot, at bit index = len; len++. Go to GAP_CHAR.
  - Else (accumulator already full): set the err flag, leave code and len unchanged, go to GAP_CHAR.
- GAP_CHAR:
  - rise -> MARK.
  - space_cnt reaching CHAR_GAP: push {err, len, code} and clear the accumulator, then go to GAP_WORD.
- GAP_WORD:
  - rise -> MARK. No separator is emitted.
  - space_cnt reaching WORD_GAP: push separator {0, 0, 0}, then go to IDLE.
  - One separator per gap. None after reset or after a discarded glitch mark with no pending elements.
- Rise and gap-threshold hit in the same cycle: the rise wins and no push occurs.
- FIFO:
  - First-word-fall-through; out_* reflect the head combinationally from storage.
  - out_valid = (fifo_count != 0).
  - Pop when out_valid & out_ready; out_ready while empty has no effect.
  - Push while full with no simultaneous pop: drop the entry and set overflow, which stays set until rst.
  - Push and pop in the same cycle while full: both succeed and the count is unchanged.
  - Push and pop in the same cycle while empty: the push is stored. Pop is ignored because out_valid=0.
  - Pointers wrap modulo DEPTH.
  - Push-to-out_valid latency is 1 cycle.
- Reset mid-character or mid-stream discards the accumulator and all FIFO contents.

Test Plan:
All scenarios use the defaults; durations are in din cycles.
- Dot-dash then low for 10: mark 2, space 3, mark 6, space 10. Expect out_len=2, out_code=2'b10, out_err=0, out_valid 1 cycle after the char-gap hit. Hold low 25 in total: second entry with len=0.
- Glitch rejection: mark 1 inside a character (".", glitch, "."). Expect len=2, code=0. A lone 1-cycle mark from IDLE produces no entry.
- Too-long character: 7 dots separated by space 3, then space 10. Expect one entry with len=6, code=0, out_err=1.
- FIFO full: hold out_ready=0 and send 9 single-dot characters. Expect fifo_count=8 and overflow=1. Then raise out_ready: 8 entries pop in order, and overflow stays 1.
- Simultaneous push and pop at full: out_ready pulses on the exact cycle of the 9th push. Expect no overflow and fifo_count remaining 8.
- Reset mid-mark: assert rst for 1 cycle during a mark with 2 entries queued. Expect fifo_count=0, out_valid=0, state IDLE. The next character decodes correctly.

Source files
------------

// File: rtl/morse_rx_fifo.sv
// Morse receiver front end: synchronises din, classifies marks/spaces, queues characters in a FWFT FIFO.
// Push-to-out_valid is 1 cycle; out_ready stalls the head; pushes into a full FIFO are dropped and flag overflow.
module morse_rx_fifo #(
    parameter int MAX_SYMBOLS = 6,
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 16,
    parameter int GLITCH_MIN  = 2,
    parameter int DASH_MIN    = 4,
    parameter int CHAR_GAP    = 8,
    parameter int WORD_GAP    = 20
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             din,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(MAX_SYMBOLS+1)-1:0] out_len,
    output logic [MAX_SYMBOLS-1:0]           out_code,
    output logic                             out_err,
    output logic [$clog2(DEPTH+1)-1:0]       fifo_count,
    output logic                             overflow
);
    localparam int LEN_W = $clog2(MAX_SYMBOLS + 1);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] GLITCH_L = CNT_W'(GLITCH_MIN);
    localparam logic [CNT_W-1:0] DASH_L   = CNT_W'(DASH_MIN);
    localparam logic [CNT_W-1:0] CHAR_L   = CNT_W'(CHAR_GAP);
    localparam logic [CNT_W-1:0] WORD_L   = CNT_W'(WORD_GAP);
    localparam logic [LEN_W-1:0] MAX_L    = LEN_W'(MAX_SYMBOLS);

    typedef enum logic [1:0] {IDLE, MARK, GAP_CHAR, GAP_WORD} state_t;

    typedef struct packed {
        logic                   err;
        logic [LEN_W-1:0]       len;
        logic [MAX_SYMBOLS-1:0] code;
    } entry_t;

    logic sync1_q, sync2_q, ds_dly_q;
    logic ds, rise, fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            ds_dly_q <= 1'b0;
        end else begin
            sync1_q  <= din;
            sync2_q  <= sync1_q;
            ds_dly_q <= sync2_q;
        end
    end

    assign ds   = sync2_q;
    assign rise = ds & ~ds_dly_q;
    assign fall = ~ds & ds_dly_q;

    // Counters restart at 1 on the edge so they hold the run length including the current cycle.
    logic [CNT_W-1:0] mark_cnt_q, mark_cnt_d, space_cnt_q, space_cnt_d;

    always_comb begin
        mark_cnt_d  = mark_cnt_q;
        space_cnt_d = space_cnt_q;
        if (rise)
            mark_cnt_d = CNT_W'(1);
        else if (ds && (mark_cnt_q != '1))
            mark_cnt_d = mark_cnt_q + CNT_W'(1);
        if (fall)
            space_cnt_d = CNT_W'(1);
        else if (!ds && (space_cnt_q != '1))
            space_cnt_d = space_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mark_cnt_q  <= '0;
            space_cnt_q <= '0;
        end else begin
            mark_cnt_q  <= mark_cnt_d;
            space_cnt_q <= space_cnt_d;
        end
    end

    state_t                 state_q, state_d, prev_q;
    logic [LEN_W-1:0]       len_q;
    logic [MAX_SYMBOLS-1:0] code_q;
    logic                   err_q;

    logic is_glitch, is_dash, have_elems, acc_full, hit_char, hit_word;

    assign is_glitch  = mark_cnt_q < GLITCH_L;
    assign is_dash    = mark_cnt_q >= DASH_L;
    assign have_elems = len_q != '0;
    assign acc_full   = len_q == MAX_L;
    assign hit_char   = ~ds & (space_cnt_d == CHAR_L);
    assign hit_word   = ~ds & (space_cnt_d == WORD_L);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prev_q  <= IDLE;
        end else begin
            state_q <= state_d;
            if (state_q != MARK && state_d == MARK)
                prev_q <= state_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (rise) state_d = MARK;
            MARK: begin
                if (fall) begin
                    if (!is_glitch || have_elems)
                        state_d = GAP_CHAR;
                    else
                        state_d = prev_q;
                end
            end
            GAP_CHAR: begin
                if (rise)          state_d = MARK;
                else if (hit_char) state_d = GAP_WORD;
            end
            GAP_WORD: begin
                if (rise)          state_d = MARK;
                else if (hit_word) state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    logic   push, acc_clr, acc_app, acc_err;
    entry_t push_dat;

    always_comb begin
        push     = 1'b0;
        push_dat = '0;
        acc_clr  = 1'b0;
        acc_app  = 1'b0;
        acc_err  = 1'b0;
        case (state_q)
            MARK: begin
                if (fall && !is_glitch) begin
                    acc_app = ~acc_full;
                    acc_err = acc_full;
                end
            end
            GAP_CHAR: begin
                if (!rise && hit_char) begin
                    push     = 1'b1;
                    push_dat = '{err: err_q, len: len_q, code: code_q};
                    acc_clr  = 1'b1;
                end
            end
            GAP_WORD: push = ~rise & hit_word;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || acc_clr) begin
            len_q  <= '0;
            code_q <= '0;
            err_q  <= 1'b0;
        end else if (acc_app) begin
            code_q <= code_q | (MAX_SYMBOLS'(is_dash) << len_q);
            len_q  <= len_q + LEN_W'(1);
        end else if (acc_err) begin
            err_q  <= 1'b1;
        end
    end

    // First-word-fall-through queue; a pop frees the slot a simultaneous full push lands in.
    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            overflow_q;
    logic            full, rd_en, wr_en;
    entry_t          head;

    assign out_valid = count_q != '0;
    assign full      = count_q == CW'(DEPTH);
    assign rd_en     = out_valid & out_ready;
    assign wr_en     = push & (~full | rd_en);

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_ptr_q] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(wr_en) - CW'(rd_en);
            if (push && !wr_en)
                overflow_q <= 1'b1;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign out_err    = out_valid & head.err;
    assign out_len    = out_valid ? head.len : '0;
    assign out_code   = out_valid ? head.code : '0;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_morse_rx_fifo.sv
// Drives key sequences into morse_rx_fifo; a run-length model predicts queued entries, a monitor checks pops.
module tb_morse_rx_fifo;
    localparam int MAX_SYMBOLS = 6;
    localparam int DEPTH       = 8;
    localparam int GLITCH_MIN  = 2;
    localparam int DASH_MIN    = 4;
    localparam int CHAR_GAP    = 8;
    localparam int WORD_GAP    = 20;

    typedef struct packed {
        logic       err;
        logic [2:0] len;
        logic [5:0] code;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst, din, out_ready;
    logic       out_valid, out_err, overflow;
    logic [2:0] out_len;
    logic [5:0] out_code;
    logic [3:0] fifo_count;

    morse_rx_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_len    (out_len),
        .out_code   (out_code),
        .out_err    (out_err),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    ent_t expq[$];
    bit   expect_accept = 1'b1;
    bit   rnd_done;

    // Reference model: character state tracked per key run, not per cycle.
    int       m_len;
    logic [5:0] m_code;
    logic     m_err;
    bit       m_sep;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_len  = 0;
        m_code = '0;
        m_err  = 1'b0;
        m_sep  = 1'b0;
        expq.delete();
    endtask

    task automatic exp_push(input ent_t e);
        if (expect_accept)
            expq.push_back(e);
    endtask

    task automatic model_mark(input int len);
        if (len >= GLITCH_MIN) begin
            m_sep = 1'b0;
            if (m_len < MAX_SYMBOLS) begin
                if (len >= DASH_MIN)
                    m_code[m_len] = 1'b1;
                m_len++;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic model_space(input int len);
        if (m_len > 0 && len >= CHAR_GAP) begin
            exp_push('{err: m_err, len: 3'(m_len), code: m_code});
            m_len  = 0;
            m_code = '0;
            m_err  = 1'b0;
            m_sep  = 1'b1;
        end
        if (m_sep && len >= WORD_GAP) begin
            exp_push('0);
            m_sep = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key_mark(input int len);
        model_mark(len);
        din = 1'b1;
        repeat (len) tick();
    endtask

    task automatic key_space(input int len);
        model_space(len);
        din = 1'b0;
        repeat (len) tick();
    endtask

    task automatic key_char(input int nel, input int gap);
        for (int e = 0; e < nel; e++) begin
            key_mark(($urandom_range(0, 1) != 0) ? 5 : 2);
            if (e < nel - 1)
                key_space(3);
        end
        key_space(gap);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 400 && expq.size() != 0; i++)
            tick();
        chk("drain_expected_empty", 32'(expq.size()), 0);
        tick();
        chk("drain_fifo_count", 32'(fifo_count), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        model_reset();
        repeat (2) tick();
    endtask

    initial begin
        rst = 1'b1;
        din = 1'b0;
        out_ready = 1'b0;
        model_reset();

        fork
            forever begin
                @(negedge clk);
                if (!rst && out_valid && out_ready) begin
                    vectors++;
                    if (expq.size() == 0) begin
                        miscompares++;
                        $display("FAIL spurious_entry: got err=%0b len=%0d code=%b, expected none",
                                 out_err, out_len, out_code);
                    end else begin
                        ent_t e;
                        e = expq.pop_front();
                        if ({out_err, out_len, out_code} !== e) begin
                            miscompares++;
                            $display("FAIL head_entry: got err=%0b len=%0d code=%b, expected err=%0b len=%0d code=%b",
                                     out_err, out_len, out_code, e.err, e.len, e.code);
                        end
                    end
                end
            end
        join_none

        do_reset();
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_fifo_count", 32'(fifo_count), 0);
        chk("reset_overflow", 32'(overflow), 0);
        chk("reset_out_len", 32'(out_len), 0);
        chk("reset_out_code", 32'(out_code), 0);
        chk("reset_out_err", 32'(out_err), 0);

        // Dot-dash; head appears exactly one cycle after the char-gap push.
        key_mark(2);
        key_space(3);
        key_mark(6);
        model_space(25);
        din = 1'b0;
        repeat (CHAR_GAP + 1) tick();
        chk("dotdash_valid_before_push", 32'(out_valid), 0);
        tick();
        chk("dotdash_valid_after_push", 32'(out_valid), 1);
        chk("dotdash_len", 32'(out_len), 2);
        chk("dotdash_code", 32'(out_code), 32'h2);
        chk("dotdash_err", 32'(out_err), 0);
        repeat (25 - CHAR_GAP - 2) tick();
        repeat (3) tick();
        chk("dotdash_with_separator_count", 32'(fifo_count), 2);
        drain();

        // Glitch inside a character, then a lone glitch from idle.
        key_mark(2);
        key_space(3);
        key_mark(1);
        key_space(3);
        key_mark(2);
        key_space(25);
        drain();
        key_mark(1);
        key_space(30);
        chk("lone_glitch_no_entry", 32'(fifo_count), 0);

        // Seven dots: accumulator saturates at MAX_SYMBOLS and flags err.
        for (int i = 0; i < 7; i++) begin
            key_mark(2);
            key_space(i == 6 ? 25 : 3);
        end
        drain();

        // Fill with out_ready low; the ninth character and its separator are dropped.
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            expect_accept = (i < 8);
            key_mark(2);
            key_space(i == 8 ? 25 : 10);
        end
        expect_accept = 1'b1;
        tick();
        chk("full_fifo_count", 32'(fifo_count), DEPTH);
        chk("full_overflow", 32'(overflow), 1);
        drain();
        chk("overflow_sticky", 32'(overflow), 1);

        // Pop on the exact cycle of the ninth push while full.
        do_reset();
        chk("reset_clears_overflow", 32'(overflow), 0);
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            key_char(1 + i % 3, 10);
        key_char(2, 0);
        model_space(25);
        din = 1'b0;
        repeat (CHAR_GAP + 1) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("simul_full_count", 32'(fifo_count), DEPTH);
        chk("simul_full_overflow", 32'(overflow), 0);
        out_ready = 1'b1;
        repeat (25 - CHAR_GAP - 2) tick();
        drain();

        // Reset during a mark with two entries queued.
        out_ready = 1'b0;
        key_char(2, 10);
        key_char(3, 10);
        din = 1'b1;
        repeat (3) tick();
        chk("pre_reset_count", 32'(fifo_count), 2);
        rst = 1'b1;
        din = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
        chk("midmark_reset_count", 32'(fifo_count), 0);
        chk("midmark_reset_valid", 32'(out_valid), 0);
        repeat (4) tick();
        out_ready = 1'b1;
        key_char(4, 25);
        drain();

        // Random streams with random backpressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int c = 0; c < 40; c++) begin
                    int nel;
                    int gsel;
                    int gap;
                    nel = $urandom_range(1, 7);
                    for (int e = 0; e < nel; e++) begin
                        key_mark($urandom_range(1, 7));
                        if (e < nel - 1)
                            key_space($urandom_range(1, CHAR_GAP - 1));
                    end
                    gsel = $urandom_range(0, 5);
                    case (gsel)
                        0:       gap = CHAR_GAP - 1;
                        1:       gap = CHAR_GAP;
                        2:       gap = $urandom_range(CHAR_GAP + 1, WORD_GAP - 2);
                        3:       gap = WORD_GAP - 1;
                        4:       gap = WORD_GAP;
                        default: gap = WORD_GAP + 5;
                    endcase
                    key_space(gap);
                end
                key_space(WORD_GAP + 5);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    tick();
                    out_ready = ($urandom_range(0, 1) != 0);
                end
            end
        join
        drain();
        chk("random_no_overflow", 32'(overflow), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
